shift_pipe_tapped: RTL and testbench

Parametrised multi-stage shift register with every stage visible on a tap output. It generalises the fixed 4×8-bit tapped delay line with:
- configurable width and depth
- shift enable
- forward, reverse and rotate modes
- parallel load and synchronous clear
- per-stage valid tracking with occupancy and full/empty flags

It serves as the generic delay-line, tap-buffer and window element in the control path.

---
 rtl/shift_pipe_tapped.sv | 104 ++++++++++
 tb/tb_shift_pipe_tapped.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_tapped.sv
// Tapped shift/rotate register with per-stage valid; din reaches the entry tap one enabled edge later.
// No backpressure: en gates every advance, clr > load > en; occupancy/full/empty decode tap_valid.
module shift_pipe_tapped #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   clr,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic [DEPTH-1:0]       load_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_valid,
  output logic [CNT_W-1:0]       occupancy,
  output logic                   full,
  output logic                   empty
);

  localparam logic [1:0] MODE_SHIFT_FWD = 2'b00;
  localparam logic [1:0] MODE_SHIFT_REV = 2'b01;
  localparam logic [1:0] MODE_ROT_FWD   = 2'b10;
  localparam logic [1:0] MODE_ROT_REV   = 2'b11;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Data and valid always move together; invalid data is carried, not zeroed.
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (clr) begin
      stage_d = '{default: '0};
      valid_d = '0;
    end else if (load) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = load_data[k*WIDTH +: WIDTH];
      end
      valid_d = load_valid;
    end else if (en) begin
      case (mode)
        MODE_SHIFT_FWD: begin
          stage_d[0] = din;
          for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
          valid_d = {valid_q[DEPTH-2:0], din_valid};
        end
        MODE_SHIFT_REV: begin
          stage_d[DEPTH-1] = din;
          for (int k = 0; k < DEPTH - 1; k++) stage_d[k] = stage_q[k+1];
          valid_d = {din_valid, valid_q[DEPTH-1:1]};
        end
        MODE_ROT_FWD: begin
          stage_d[0] = stage_q[DEPTH-1];
          for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
          valid_d = {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
        end
        MODE_ROT_REV: begin
          stage_d[DEPTH-1] = stage_q[0];
          for (int k = 0; k < DEPTH - 1; k++) stage_d[k] = stage_q[k+1];
          valid_d = {valid_q[0], valid_q[DEPTH-1:1]};
        end
        default: begin
          stage_d = stage_q;
          valid_d = valid_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '{default: '0};
      valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_tap
    assign taps[g*WIDTH +: WIDTH] = stage_q[g];
  end

  assign tap_valid = valid_q;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CNT_W'(valid_q[k]);
    end
  end

  assign full  = (occupancy == CNT_W'(DEPTH));
  assign empty = (occupancy == '0);

endmodule

// File: tb/tb_shift_pipe_tapped.sv
// Scoreboard bench: a queue-based model predicts every post-edge state; a monitor checks each cycle.
module tb_shift_pipe_tapped;
  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [1:0]      mode;
  logic [W-1:0]    din;
  logic            din_valid;
  logic            clr;
  logic            load;
  logic [W*D-1:0]  load_data;
  logic [D-1:0]    load_valid;
  logic [W*D-1:0]  taps;
  logic [D-1:0]    tap_valid;
  logic [CW-1:0]   occupancy;
  logic            full;
  logic            empty;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [W-1:0] d; logic v; } cell_t;
  typedef struct packed { logic [W*D-1:0] taps; logic [D-1:0] tv; logic [CW-1:0] occ; } exp_t;

  cell_t pipe[$];   // index 0 is stage 0
  exp_t  exp_q[$];

  shift_pipe_tapped #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
    .clr(clr), .load(load), .load_data(load_data), .load_valid(load_valid),
    .taps(taps), .tap_valid(tap_valid), .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    cell_t z;
    z.d = '0;
    z.v = 1'b0;
    pipe.delete();
    for (int k = 0; k < D; k++) pipe.push_back(z);
  endfunction

  always @(posedge reset) model_clear();

  // Reference model: the pipeline as a deque of (data, valid) cells.
  always @(posedge clk) begin
    cell_t c;
    exp_t  e;
    int    n;
    if (reset || clr || pipe.size() != D) begin
      model_clear();
    end else if (load) begin
      pipe.delete();
      for (int k = 0; k < D; k++) begin
        c.d = load_data[k*W +: W];
        c.v = load_valid[k];
        pipe.push_back(c);
      end
    end else if (en) begin
      case (mode)
        2'b00: begin void'(pipe.pop_back());  c.d = din; c.v = din_valid; pipe.push_front(c); end
        2'b01: begin void'(pipe.pop_front()); c.d = din; c.v = din_valid; pipe.push_back(c); end
        2'b10: begin c = pipe.pop_back();  pipe.push_front(c); end
        default: begin c = pipe.pop_front(); pipe.push_back(c); end
      endcase
    end
    n = 0;
    for (int k = 0; k < D; k++) begin
      e.taps[k*W +: W] = pipe[k].d;
      e.tv[k] = pipe[k].v;
      if (pipe[k].v) n++;
    end
    e.occ = CW'(n);
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected a prediction");
    end else begin
      e = exp_q.pop_front();
      chk("sb_taps", 64'(taps), 64'(e.taps));
      chk("sb_tap_valid", 64'(tap_valid), 64'(e.tv));
      chk("sb_occupancy", 64'(occupancy), 64'(e.occ));
      chk("sb_full", 64'(full), 64'(e.occ == CW'(D)));
      chk("sb_empty", 64'(empty), 64'(e.occ == '0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [W*D-1:0] t, input logic [D-1:0] v,
                           input logic [CW-1:0] o);
    chk({name, "_taps"}, 64'(taps), 64'(t));
    chk({name, "_tap_valid"}, 64'(tap_valid), 64'(v));
    chk({name, "_occupancy"}, 64'(occupancy), 64'(o));
  endtask

  initial begin
    logic [W-1:0] fwd_din [4];
    fwd_din = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; idle(); mode = 2'b00; din = '0; din_valid = 1'b0;
    load_data = '0; load_valid = '0;
    tick(); tick();
    chk_state("reset", '0, '0, '0);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    reset = 1'b0;
    tick();

    // Forward shift, then an invalid entry
    en = 1'b1; mode = 2'b00; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = fwd_din[i];
      tick();
    end
    chk_state("fwd4", 32'h11223344, 4'b1111, 3'd4);
    chk("fwd4_full", 64'(full), 64'd1);
    din = 8'h55; din_valid = 1'b0;
    tick();
    chk_state("fwd_inv", 32'h22334455, 4'b1110, 3'd3);

    // Reverse with an enable gap
    mode = 2'b01; din = 8'hA1; din_valid = 1'b1;
    tick();
    chk_state("rev1", 32'hA1223344, 4'b1111, 3'd4);
    en = 1'b0; din = 8'hEE;
    tick();
    chk_state("rev_hold", 32'hA1223344, 4'b1111, 3'd4);
    en = 1'b1; din = 8'hA2;
    tick();
    chk_state("rev2", 32'hA2A12233, 4'b1111, 3'd4);

    // Load then rotate both ways; din must be ignored
    idle(); load = 1'b1; load_data = 32'h04030201; load_valid = 4'b0101;
    tick();
    chk_state("load", 32'h04030201, 4'b0101, 3'd2);
    idle(); en = 1'b1; mode = 2'b10; din = 8'hFF; din_valid = 1'b1;
    tick();
    chk_state("rotf", 32'h03020104, 4'b1010, 3'd2);
    mode = 2'b11;
    tick();
    chk_state("rotr1", 32'h04030201, 4'b0101, 3'd2);
    tick();
    chk_state("rotr2", 32'h01040302, 4'b1010, 3'd2);

    // clr beats load and en; load beats en
    clr = 1'b1; load = 1'b1; en = 1'b1; mode = 2'b00;
    tick();
    chk_state("clr_prio", '0, '0, '0);
    clr = 1'b0; load_data = 32'hDEADBEEF; load_valid = 4'b1011; din = 8'h77;
    tick();
    chk_state("load_prio", 32'hDEADBEEF, 4'b1011, 3'd3);

    // Async reset mid-stream, observed before any clock edge
    idle(); en = 1'b1; mode = 2'b00;
    tick();
    reset = 1'b1;
    #1;
    chk_state("async_rst", '0, '0, '0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 14) == 0);
      en = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      din = W'($urandom);
      din_valid = 1'($urandom);
      load_data = $urandom;
      load_valid = D'($urandom);
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
